// File: rtl/dn_switch_node_pkg.sv
// dn_switch_node_pkg
// Shared definitions for the distribution-network switch node.
//   cfg_state_e  : commit state (idle, or a commit waiting for the node to drain)
//   idx_width()  : index width for a port count, never narrower than one bit
//   reset_route(): route an output takes out of reset (output o listens to input o mod NUM_IN)
package dn_switch_node_pkg;

   typedef enum logic {
      CFG_IDLE,
      CFG_PENDING
   } cfg_state_e;

   // A single-port side still needs a one-bit index field so that the
   // configuration bus keeps a legal width.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Identity-like routing; wraps when there are more outputs than inputs.
   function automatic int reset_route(input int o, input int num_in);
      return o % num_in;
   endfunction

endpackage

// File: rtl/dn_switch_node_if.sv
// dn_switch_node_if
// Bundles the configuration port and the per-port valid/ready data buses
// of dn_switch_node.
//   master : drives cfg_*, in_valid/in_data, out_ready; observes busy, in_ready, out_valid/out_data
//   slave  : the switch node itself
// Input i lives at in_data[i*DW_DATA +: DW_DATA]; output o at out_data[o*DW_DATA +: DW_DATA].
interface dn_switch_node_if
   import dn_switch_node_pkg::*;
#(
   parameter int DW_DATA = 8,
   parameter int NUM_IN  = 2,
   parameter int NUM_OUT = 2
);

   localparam int PORT_W = idx_width(NUM_OUT);
   localparam int SEL_W  = idx_width(NUM_IN);

   logic                        cfg_we;
   logic [PORT_W-1:0]           cfg_port;
   logic [SEL_W-1:0]            cfg_sel;
   logic                        cfg_en;
   logic                        cfg_commit;
   logic                        busy;

   logic [NUM_IN-1:0]           in_valid;
   logic [NUM_IN*DW_DATA-1:0]   in_data;
   logic [NUM_IN-1:0]           in_ready;

   logic [NUM_OUT-1:0]          out_valid;
   logic [NUM_OUT*DW_DATA-1:0]  out_data;
   logic [NUM_OUT-1:0]          out_ready;

   modport master (
      output cfg_we, cfg_port, cfg_sel, cfg_en, cfg_commit,
      output in_valid, in_data, out_ready,
      input  busy, in_ready, out_valid, out_data
   );

   modport slave (
      input  cfg_we, cfg_port, cfg_sel, cfg_en, cfg_commit,
      input  in_valid, in_data, out_ready,
      output busy, in_ready, out_valid, out_data
   );

endinterface

// File: rtl/dn_switch_node_out_reg.sv
// dn_switch_node_out_reg
// One-entry valid/ready pipeline register feeding a single switch output.
//   clk, reset : clock and asynchronous active-high reset
//   load       : capture load_data this cycle (the caller guarantees room)
//   load_data  : beat to capture
//   out_ready  : downstream accepts the current entry
//   out_valid  : entry is occupied
//   out_data   : entry contents; held after the entry drains
module dn_switch_node_out_reg #(
   parameter int DW_DATA = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [DW_DATA-1:0] load_data,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DW_DATA-1:0] out_data
);

   logic               valid_q, valid_d;
   logic [DW_DATA-1:0] data_q, data_d;

   // A load always wins: it either fills an empty entry or replaces one that
   // is leaving this same cycle. Without a load, an accepted entry simply
   // empties while its data stays put.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/dn_switch_node.sv
// dn_switch_node
// NUM_IN x NUM_OUT switch node of the sparse distribution network. Every
// output picks one input (several outputs may pick the same input for
// multicast). Routes are written into a shadow table and copied into the
// active table only when every output register is empty.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : dn_switch_node_if slave (config, busy, per-port valid/ready data)
module dn_switch_node
   import dn_switch_node_pkg::*;
#(
   parameter int DW_DATA = 8,
   parameter int NUM_IN  = 2,
   parameter int NUM_OUT = 2
) (
   input  logic            clk,
   input  logic            reset,
   dn_switch_node_if.slave bus
);

   localparam int SEL_W = idx_width(NUM_IN);

   cfg_state_e         state_q, state_d;
   logic [SEL_W-1:0]   shadow_sel_q [NUM_OUT];
   logic [SEL_W-1:0]   shadow_sel_d [NUM_OUT];
   logic [NUM_OUT-1:0] shadow_en_q, shadow_en_d;
   logic [SEL_W-1:0]   active_sel_q [NUM_OUT];
   logic [SEL_W-1:0]   active_sel_d [NUM_OUT];
   logic [NUM_OUT-1:0] active_en_q, active_en_d;

   logic               cfg_ok;
   logic               drained;
   logic [NUM_OUT-1:0] out_valid;
   logic [NUM_OUT-1:0] can_load;
   logic [NUM_OUT-1:0] load;
   logic [DW_DATA-1:0] load_data [NUM_OUT];
   logic [NUM_IN-1:0]  in_ready;
   logic [NUM_IN-1:0]  fire;

   // Shadow table update. Out-of-range port or select values are dropped so
   // the active table can only ever hold routes that exist.
   always_comb begin
      shadow_sel_d = shadow_sel_q;
      shadow_en_d  = shadow_en_q;
      cfg_ok = bus.cfg_we
               && (int'(bus.cfg_port) < NUM_OUT)
               && (int'(bus.cfg_sel) < NUM_IN);
      if (cfg_ok) begin
         shadow_sel_d[bus.cfg_port] = bus.cfg_sel;
         shadow_en_d[bus.cfg_port]  = bus.cfg_en;
      end
   end

   // Commit FSM. The copy takes the shadow table including any write made in
   // the same cycle, so a write+commit pair behaves as one operation. If data
   // is still sitting in the outputs the commit waits in CFG_PENDING, which
   // also stalls all inputs so the node is guaranteed to empty out.
   always_comb begin
      state_d      = state_q;
      active_sel_d = active_sel_q;
      active_en_d  = active_en_q;
      case (state_q)
         CFG_IDLE: begin
            if (bus.cfg_commit) begin
               if (drained) begin
                  active_sel_d = shadow_sel_d;
                  active_en_d  = shadow_en_d;
               end else begin
                  state_d = CFG_PENDING;
               end
            end
         end
         CFG_PENDING: begin
            if (drained) begin
               active_sel_d = shadow_sel_d;
               active_en_d  = shadow_en_d;
               state_d      = CFG_IDLE;
            end
         end
         default: state_d = CFG_IDLE;
      endcase
   end

   // Both route tables and the commit state come out of reset with the
   // default (o mod NUM_IN) routing, every output enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CFG_IDLE;
         for (int o = 0; o < NUM_OUT; o++) begin
            shadow_sel_q[o] <= SEL_W'(reset_route(o, NUM_IN));
            active_sel_q[o] <= SEL_W'(reset_route(o, NUM_IN));
         end
         shadow_en_q <= '1;
         active_en_q <= '1;
      end else begin
         state_q      <= state_d;
         shadow_sel_q <= shadow_sel_d;
         shadow_en_q  <= shadow_en_d;
         active_sel_q <= active_sel_d;
         active_en_q  <= active_en_d;
      end
   end

   assign drained  = ~|out_valid;
   assign can_load = ~out_valid | bus.out_ready;

   // An input may only fire when every output that listens to it can take the
   // beat, which keeps multicast all-or-nothing. An input nobody listens to is
   // always ready and its beats are dropped. Nothing here looks at in_valid.
   always_comb begin
      in_ready = {NUM_IN{state_q == CFG_IDLE}};
      for (int i = 0; i < NUM_IN; i++) begin
         for (int o = 0; o < NUM_OUT; o++) begin
            if (active_en_q[o] && (active_sel_q[o] == SEL_W'(i)) && !can_load[o]) begin
               in_ready[i] = 1'b0;
            end
         end
      end
   end

   assign fire = bus.in_valid & in_ready;

   // Per-output input mux: an enabled output loads whenever its selected
   // input fires. Disabled outputs never load but still drain.
   always_comb begin
      load = '0;
      for (int o = 0; o < NUM_OUT; o++) begin
         load_data[o] = '0;
         for (int i = 0; i < NUM_IN; i++) begin
            if (active_sel_q[o] == SEL_W'(i)) begin
               load[o]      = active_en_q[o] & fire[i];
               load_data[o] = bus.in_data[i*DW_DATA +: DW_DATA];
            end
         end
      end
   end

   for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
      dn_switch_node_out_reg #(
         .DW_DATA (DW_DATA)
      ) u_out_reg (
         .clk       (clk),
         .reset     (reset),
         .load      (load[o]),
         .load_data (load_data[o]),
         .out_ready (bus.out_ready[o]),
         .out_valid (out_valid[o]),
         .out_data  (bus.out_data[o*DW_DATA +: DW_DATA])
      );
   end

   assign bus.out_valid = out_valid;
   assign bus.in_ready  = in_ready;
   assign bus.busy      = (state_q == CFG_PENDING);

endmodule
